// File: rtl/grid_move_engine_if.sv
// ============================================================================
// Module      : grid_move_engine_if
// Description : Request/result bundle for the grid move engine. The master
//               side issues a move (start, dir, grid_in, rand_in). The slave
//               side reports status and the resulting grid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface grid_move_engine_if #(
  parameter int N  = 4,
  parameter int TW = 4,
  parameter int RW = 16
);
  localparam int c_gw  = N * N * TW;
  localparam int c_bcw = $clog2(N * N + 1);

  // request side
  logic               start;
  logic [3:0]         dir;
  logic [c_gw-1:0]    grid_in;
  logic [RW-1:0]      rand_in;

  // result side
  logic               busy;
  logic               done;
  logic [c_gw-1:0]    grid_out;
  logic               moved;
  logic [c_bcw-1:0]   blank_count;
  logic               lose;
  logic               win;

  modport master (
    output start, dir, grid_in, rand_in,
    input  busy, done, grid_out, moved, blank_count, lose, win
  );

  modport slave (
    input  start, dir, grid_in, rand_in,
    output busy, done, grid_out, moved, blank_count, lose, win
  );
endinterface

`default_nettype wire

// File: rtl/grid_move_engine.sv
// ============================================================================
// Module      : grid_move_engine
// Description : Sliding-tile (2048-style) move engine. Latches a source grid
//               and a one-hot direction, slides/merges one line per cycle,
//               spawns a new tile into a random blank, then evaluates the
//               blank count, lose and win flags and reports them with done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_move_engine #(
  parameter int N   = 4,
  parameter int TW  = 4,
  parameter int RW  = 16,
  parameter int WIN = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  grid_move_engine_if.slave bus
);

  localparam int c_gw  = N * N * TW;
  localparam int c_bcw = $clog2(N * N + 1);
  localparam int c_lw  = $clog2(N);

  localparam logic [TW-1:0]   c_tile_max = '1;
  localparam logic [c_lw-1:0] c_last_line = c_lw'(N - 1);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_slide = 3'd1;
  localparam logic [2:0] c_spawn = 3'd2;
  localparam logic [2:0] c_check = 3'd3;
  localparam logic [2:0] c_done  = 3'd4;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]       r_state;
  logic [c_lw-1:0]  r_line;
  logic [3:0]       r_dir;
  logic [c_gw-1:0]  r_src;
  logic [c_gw-1:0]  r_grid;
  logic             r_merge_win;
  logic             r_moved;
  logic [c_bcw-1:0] r_chk_blanks;
  logic             r_chk_lose;
  logic             r_chk_win;
  logic             r_done;
  logic [c_gw-1:0]  r_grid_out;
  logic             r_moved_out;
  logic [c_bcw-1:0] r_blank_out;
  logic             r_lose_out;
  logic             r_win_out;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic             w_dir_ok;
  logic [c_gw-1:0]  w_slid;
  logic             w_merge_win;
  logic [c_bcw-1:0] w_blanks;
  logic             w_has_pair;
  logic             w_moved;
  logic [TW-1:0]    w_spawn_val;
  logic [c_gw-1:0]  w_spawned;
  logic             w_accept;

  // Flat tile index of position pos (0 = leading edge) in line ln for the
  // direction d. Up/down walk columns, left/right walk rows.
  function automatic int tile_idx(input logic [3:0] d, input int ln, input int pos);
    if (d[3])      return pos * N + ln;
    else if (d[2]) return (N - 1 - pos) * N + ln;
    else if (d[1]) return ln * N + pos;
    else           return ln * N + (N - 1 - pos);
  endfunction

  assign w_dir_ok = (r_dir != 4'b0000) && ((r_dir & (r_dir - 4'd1)) == 4'b0000);
  assign w_moved  = (r_grid != r_src);
  assign w_accept = (r_state == c_idle) && bus.start && !r_done;

  // The spawn value is 2 only when the top nibble of the random word is zero.
  assign w_spawn_val = (bus.rand_in[RW-1 -: 4] == 4'd0) ? TW'(2) : TW'(1);

  // Slide and merge the current line toward its leading edge.
  always_comb begin
    logic [TW-1:0] l_line [N];
    logic [TW-1:0] l_cmp  [N+1];
    logic [TW-1:0] l_res  [N];
    int            l_o;
    logic          l_skip;

    w_slid      = r_grid;
    w_merge_win = 1'b0;
    l_o         = 0;
    l_skip      = 1'b0;
    for (int j = 0; j < N; j++) begin
      l_line[j] = r_grid[tile_idx(r_dir, int'(r_line), j) * TW +: TW];
      l_res[j]  = '0;
    end
    for (int j = 0; j <= N; j++) begin
      l_cmp[j] = '0;
    end

    // compaction: non-zero tiles keep their order, packed toward slot 0
    for (int j = 0; j < N; j++) begin
      if (l_line[j] != '0) begin
        l_cmp[l_o] = l_line[j];
        l_o        = l_o + 1;
      end
    end

    // merge scan from the leading edge; the extra zero slot l_cmp[N] keeps
    // the look-ahead in range and never matches a non-zero tile
    l_o = 0;
    for (int j = 0; j < N; j++) begin
      if (l_skip) begin
        l_skip = 1'b0;
      end else if (l_cmp[j] != '0) begin
        if ((l_cmp[j] == l_cmp[j+1]) && (l_cmp[j] != c_tile_max)) begin
          l_res[l_o] = l_cmp[j] + 1'b1;
          if ((int'(l_cmp[j]) + 1) >= WIN) begin
            w_merge_win = 1'b1;
          end
          l_skip = 1'b1;
        end else begin
          l_res[l_o] = l_cmp[j];
        end
        l_o = l_o + 1;
      end
    end

    // an illegal direction leaves every line untouched
    if (w_dir_ok) begin
      for (int j = 0; j < N; j++) begin
        w_slid[tile_idx(r_dir, int'(r_line), j) * TW +: TW] = l_res[j];
      end
    end else begin
      w_merge_win = 1'b0;
    end
  end

  // Count blanks and look for any orthogonally equal neighbour pair.
  always_comb begin
    w_blanks   = '0;
    w_has_pair = 1'b0;
    for (int i = 0; i < N * N; i++) begin
      if (r_grid[i*TW +: TW] == '0) begin
        w_blanks = w_blanks + c_bcw'(1);
      end
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N - 1; c++) begin
        if (r_grid[(r*N + c)*TW +: TW] == r_grid[(r*N + c + 1)*TW +: TW]) begin
          w_has_pair = 1'b1;
        end
      end
    end
    for (int r = 0; r < N - 1; r++) begin
      for (int c = 0; c < N; c++) begin
        if (r_grid[(r*N + c)*TW +: TW] == r_grid[((r + 1)*N + c)*TW +: TW]) begin
          w_has_pair = 1'b1;
        end
      end
    end
  end

  // Place the spawn tile into blank number (rand_in mod blanks), row-major.
  always_comb begin
    logic [c_bcw-1:0] l_div;
    int               l_k;
    int               l_cnt;

    l_div     = (w_blanks == '0) ? c_bcw'(1) : w_blanks;
    l_k       = int'(bus.rand_in % RW'(l_div));
    l_cnt     = 0;
    w_spawned = r_grid;
    for (int i = 0; i < N * N; i++) begin
      if (r_grid[i*TW +: TW] == '0) begin
        if (l_cnt == l_k) begin
          w_spawned[i*TW +: TW] = w_spawn_val;
        end
        l_cnt = l_cnt + 1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer: IDLE -> SLIDE (N lines) -> SPAWN -> CHECK -> DONE -> IDLE.
  // The done pulse is registered on the DONE exit edge; start is not
  // accepted during that pulse so the next move begins the cycle after it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_idle;
      r_line       <= '0;
      r_dir        <= '0;
      r_src        <= '0;
      r_grid       <= '0;
      r_merge_win  <= 1'b0;
      r_moved      <= 1'b0;
      r_chk_blanks <= '0;
      r_chk_lose   <= 1'b0;
      r_chk_win    <= 1'b0;
      r_done       <= 1'b0;
      r_grid_out   <= '0;
      r_moved_out  <= 1'b0;
      r_blank_out  <= '0;
      r_lose_out   <= 1'b0;
      r_win_out    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_src       <= bus.grid_in;
            r_grid      <= bus.grid_in;
            r_dir       <= bus.dir;
            r_line      <= '0;
            r_merge_win <= 1'b0;
            r_state     <= c_slide;
          end
        end
        c_slide: begin
          r_grid      <= w_slid;
          r_merge_win <= r_merge_win | w_merge_win;
          r_line      <= r_line + 1'b1;
          if (r_line == c_last_line) begin
            r_state <= c_spawn;
          end
        end
        c_spawn: begin
          r_moved <= w_moved;
          if (w_moved && (w_blanks != '0)) begin
            r_grid <= w_spawned;
          end
          r_state <= c_check;
        end
        c_check: begin
          r_chk_blanks <= w_blanks;
          r_chk_lose   <= (w_blanks == '0) && !w_has_pair;
          r_chk_win    <= r_merge_win;
          r_state      <= c_done;
        end
        c_done: begin
          r_grid_out  <= r_grid;
          r_moved_out <= r_moved;
          r_blank_out <= r_chk_blanks;
          r_lose_out  <= r_chk_lose;
          r_win_out   <= r_chk_win;
          r_done      <= 1'b1;
          r_state     <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign bus.busy        = (r_state != c_idle) || r_done;
  assign bus.done        = r_done;
  assign bus.grid_out    = r_grid_out;
  assign bus.moved       = r_moved_out;
  assign bus.blank_count = r_blank_out;
  assign bus.lose        = r_lose_out;
  assign bus.win         = r_win_out;

endmodule

`default_nettype wire

// File: tb/tb_grid_move_engine.sv
// ============================================================================
// Module      : tb_grid_move_engine
// Description : Scoreboard bench for grid_move_engine (N=4, TW=4). Expected
//               results are queued when a move is issued and compared when
//               done is observed.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_grid_move_engine;

  localparam int N   = 4;
  localparam int TW  = 4;
  localparam int RW  = 16;
  localparam int WIN = 11;
  localparam int LAT = N + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  grid_move_engine_if #(.N(N), .TW(TW), .RW(RW)) bus ();

  grid_move_engine #(.N(N), .TW(TW), .RW(RW), .WIN(WIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] grid;
    logic        moved;
    logic [4:0]  blanks;
    logic        lose;
    logic        win;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] g, input logic mv, input int nb,
                              input logic ls, input logic wn);
    exp_t e;
    e.grid = g; e.moved = mv; e.blanks = 5'(nb); e.lose = ls; e.win = wn;
    return e;
  endfunction

  // Reference 2048 move on a 4x4 grid of 4-bit exponents.
  function automatic exp_t model(input logic [63:0] g, input logic [3:0] d, input logic [15:0] rnd);
    exp_t       e;
    logic [3:0] t [4][4];
    logic [3:0] nz[$];
    logic [3:0] outl[$];
    int         rr[4];
    int         cc[4];
    logic [63:0] pre;
    int         nb, k, seen, i;
    bit         pair;
    e.win = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = g[(r*4 + c)*4 +: 4];
    if (d == 4'b1000 || d == 4'b0100 || d == 4'b0010 || d == 4'b0001) begin
      for (int ln = 0; ln < 4; ln++) begin
        for (int p = 0; p < 4; p++) begin
          if (d == 4'b1000)      begin rr[p] = p;     cc[p] = ln;    end
          else if (d == 4'b0100) begin rr[p] = 3 - p; cc[p] = ln;    end
          else if (d == 4'b0010) begin rr[p] = ln;    cc[p] = p;     end
          else                   begin rr[p] = ln;    cc[p] = 3 - p; end
        end
        nz.delete();
        outl.delete();
        for (int p = 0; p < 4; p++)
          if (t[rr[p]][cc[p]] != 4'd0) nz.push_back(t[rr[p]][cc[p]]);
        i = 0;
        while (i < nz.size()) begin
          if (i + 1 < nz.size() && nz[i] == nz[i+1] && nz[i] != 4'd15) begin
            outl.push_back(4'(nz[i] + 4'd1));
            if (int'(nz[i]) + 1 >= WIN) e.win = 1'b1;
            i += 2;
          end else begin
            outl.push_back(nz[i]);
            i += 1;
          end
        end
        for (int p = 0; p < 4; p++)
          t[rr[p]][cc[p]] = (p < outl.size()) ? outl[p] : 4'd0;
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pre[(r*4 + c)*4 +: 4] = t[r][c];
    e.moved = (pre != g);
    nb = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (t[r][c] == 4'd0) nb++;
    if (e.moved && nb > 0) begin
      k = int'(rnd) % nb;
      seen = 0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (t[r][c] == 4'd0) begin
            if (seen == k) t[r][c] = (rnd[15:12] == 4'd0) ? 4'd2 : 4'd1;
            seen++;
          end
    end
    nb = 0;
    pair = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        e.grid[(r*4 + c)*4 +: 4] = t[r][c];
        if (t[r][c] == 4'd0) nb++;
        if (c < 3 && t[r][c] == t[r][(c < 3) ? c + 1 : c]) pair = 1'b1;
        if (r < 3 && t[r][c] == t[(r < 3) ? r + 1 : r][c]) pair = 1'b1;
      end
    e.blanks = 5'(nb);
    e.lose   = (nb == 0) && !pair;
    return e;
  endfunction

  // Scoreboard consumer: every done pulse pops and compares one result.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      check_val("done_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check_val("grid_out",    bus.grid_out,          mon_e.grid);
        check_val("moved",       64'(bus.moved),        64'(mon_e.moved));
        check_val("blank_count", 64'(bus.blank_count),  64'(mon_e.blanks));
        check_val("lose",        64'(bus.lose),         64'(mon_e.lose));
        check_val("win",         64'(bus.win),          64'(mon_e.win));
      end
    end
  end

  // Issue one move, check busy and latency; optionally poke start mid-move.
  task automatic run_move(input logic [63:0] g, input logic [3:0] d, input logic [15:0] rnd,
                          input exp_t e, input bit poke);
    int cyc;
    bit seen;
    @(negedge clk);
    bus.grid_in = g;
    bus.dir     = d;
    bus.rand_in = rnd;
    bus.start   = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check_val("busy_after_accept", 64'(bus.busy), 64'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 2) begin
        bus.start   = 1'b1;
        bus.grid_in = ~g;
        bus.dir     = 4'b0010;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check_val("latency", 64'(cyc), 64'(LAT));
    @(negedge clk);
    check_val("done_one_cycle", 64'(bus.done), 64'd0);
  endtask

  logic [63:0] rg;
  logic [3:0]  rd;
  logic [15:0] rr16;
  int          pick;

  initial begin
    bus.start   = 1'b0;
    bus.dir     = 4'b0000;
    bus.grid_in = '0;
    bus.rand_in = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy",   64'(bus.busy),        64'd0);
    check_val("rst_done",   64'(bus.done),        64'd0);
    check_val("rst_grid",   bus.grid_out,         64'd0);
    check_val("rst_moved",  64'(bus.moved),       64'd0);
    check_val("rst_blanks", 64'(bus.blank_count), 64'd0);
    check_val("rst_lose",   64'(bus.lose),        64'd0);
    check_val("rst_win",    64'(bus.win),         64'd0);
    rst_n = 1'b1;

    // row0 [1,1,1,1] left -> [2,2,0,0]; 0x1006 mod 14 = 0 -> blank (0,2) gets 1
    run_move(64'h0000_0000_0000_1111, 4'b0010, 16'h1006, mk(64'h0000_0000_0000_0122, 1, 13, 0, 0), 0);
    // same move with a zero top nibble spawns a 2
    run_move(64'h0000_0000_0000_1111, 4'b0010, 16'h0000, mk(64'h0000_0000_0000_0222, 1, 13, 0, 0), 0);
    // row0 [1,1,2,0] left -> [2,2,0,0], no double merge
    run_move(64'h0000_0000_0000_0211, 4'b0010, 16'h1006, mk(64'h0000_0000_0000_0122, 1, 13, 0, 0), 0);
    // column 0 [3,0,3,3] down -> [0,0,3,4]; spawn 1 at tile 0
    run_move(64'h0003_0003_0000_0003, 4'b0100, 16'h1006, mk(64'h0004_0003_0000_0001, 1, 13, 0, 0), 0);
    // checkerboard: stuck, lose
    run_move(64'h1212_2121_1212_2121, 4'b1000, 16'h1006, mk(64'h1212_2121_1212_2121, 0, 0, 1, 0), 0);
    // saturated 15+15 never merge
    run_move(64'h0000_0000_0000_00FF, 4'b0010, 16'h1006, mk(64'h0000_0000_0000_00FF, 0, 14, 0, 0), 0);
    // 10+10 -> 11 raises win; 4102 mod 15 = 7 -> tile 8 gets 1
    run_move(64'h0000_0000_0000_00AA, 4'b0010, 16'h1006, mk(64'h0000_0001_0000_000B, 1, 14, 0, 1), 0);
    // illegal direction: pass-through, no spawn; a start poked mid-move is ignored
    run_move(64'h0000_0000_0000_0011, 4'b0011, 16'h1006, mk(64'h0000_0000_0000_0011, 0, 14, 0, 0), 1);
    repeat (12) @(negedge clk);
    check_val("hold_grid_out", bus.grid_out, 64'h0000_0000_0000_0011);
    // row0 [1,1,1,0] right -> [0,0,1,2]; spawn 1 at tile 0
    run_move(64'h0000_0000_0000_0111, 4'b0001, 16'h1006, mk(64'h0000_0000_0000_2101, 1, 13, 0, 0), 0);
    // column 1 [0,2,0,2] up -> [3,0,0,0]; 4102 mod 15 = 7 -> tile 8 gets 1
    run_move(64'h0020_0000_0020_0000, 4'b1000, 16'h1006, mk(64'h0000_0001_0000_0030, 1, 14, 0, 0), 0);

    // randomised moves checked against the reference model
    for (int it = 0; it < 24; it++) begin
      for (int t = 0; t < 16; t++) begin
        pick = (it % 6 == 5) ? $urandom_range(3, 9) : $urandom_range(0, 9);
        if (pick <= 2)      rg[t*4 +: 4] = 4'd0;
        else if (pick <= 7) rg[t*4 +: 4] = 4'(pick - 2);
        else if (pick == 8) rg[t*4 +: 4] = 4'd10;
        else                rg[t*4 +: 4] = 4'd15;
      end
      rd   = (it % 8 == 7) ? 4'b0101 : 4'(1 << $urandom_range(0, 3));
      rr16 = 16'($urandom);
      if (it % 3 == 0) rr16 = rr16 & 16'h0FFF;
      run_move(rg, rd, rr16, model(rg, rd, rr16), 0);
    end

    // reset in the third SLIDE cycle aborts the move
    @(negedge clk);
    bus.grid_in = 64'h0000_0000_0000_1111;
    bus.dir     = 4'b0010;
    bus.rand_in = 16'h1006;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", 64'(bus.busy),  64'd0);
    check_val("abort_grid", bus.grid_out,   64'd0);
    check_val("abort_done", 64'(bus.done),  64'd0);
    check_val("abort_win",  64'(bus.win),   64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("abort_no_done", 64'(bus.done), 64'd0);
    run_move(64'h0000_0000_0000_1111, 4'b0010, 16'h1006, mk(64'h0000_0000_0000_0122, 1, 13, 0, 0), 0);

    repeat (5) @(negedge clk);
    check_val("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
